mem_slot_requester: RTL and testbench
=====================================

// Module: mem_slot_requester
// PURPOSE
//   Per-core request buffer that sits directly upstream of memorycontroller, one instance per core port.
//   It accepts one core load/store through a valid/ready handshake and holds it stable on the controller
//   port until the core's time-division slot arrives. It then returns read data, or a write acknowledge,
//   through a one-cycle response pulse. Its slot counter mirrors the controller's 3-bit round-robin counter.
// PARAMETERS
//   SLOT_ID    0   controller slot (0..NUM_SLOTS-1) that this instance's port is served in
//   NUM_SLOTS  8   slots per controller round; must be a power of 2
//   ADDR_W     12  address width
//   DATA_W     16  data width
// PORTS
//   clk16      in   1       system clock, shared with memorycontroller
//   rst_n      in   1       reset, asynchronous assert, active-low
//   req_valid  in   1       core request present
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   req_ready  out  1       buffer can accept a request
//   resp_valid out  1       one-cycle pulse: load data valid or store done
//   resp_rdata out  DATA_W  load data; holds its value until the next load completes
//   mc_addr    out  ADDR_W  to controller addrN_
//   mc_we      out  1       to controller weN_
//   mc_wdata   out  DATA_W  to controller dataINN_
//   mc_rdata   in   DATA_W  from controller dataOUTN_
// BEHAVIOUR
//   Clock, reset and reset values
//   - Single clock clk16. rst_n is asynchronous, active-low.
//   - Reset values: slot_cnt=0, state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mc_addr=0,
//     mc_we=0, mc_wdata=0.
//   - slot_cnt is a log2(NUM_SLOTS)-bit register that increments every cycle and wraps N-1 -> 0.
//     Reset must release on the same edge the controller counter leaves 0, so both counters stay in phase.
//   - "Slot edge" is the rising edge at which slot_cnt==SLOT_ID. The controller samples this port on it.
//   Handshake
//   - req_ready = (state==IDLE). A request is accepted on an edge where req_valid && req_ready.
//   - On accept: latch addr, we and wdata into mc_addr, mc_we and mc_wdata; go to WAIT_SLOT.
//   - mc_addr and mc_wdata are held unchanged until the next accept.
//   States
//   - IDLE      -> WAIT_SLOT on accept. An accept on a slot edge misses that slot and waits one
//                  full round.
//   - WAIT_SLOT -> on the next slot edge: clear mc_we on the same edge, so each store is written
//                  exactly once. A store then goes to DONE; a load goes to WAIT_DATA.
//   - WAIT_DATA -> the controller registers mc_rdata on the following slot edge (NUM_SLOTS edges later).
//                  On the edge after that (slot_cnt==SLOT_ID+1 mod N), capture mc_rdata into
//                  resp_rdata and go to DONE.
//   - DONE      -> resp_valid=1 for exactly this cycle, then go to IDLE. req_ready is 0 in DONE.
//   Latency, counted from the slot edge to the resp_valid cycle
//   - Store: resp_valid is high in the cycle after the slot edge.
//   - Load: resp_valid is high NUM_SLOTS+2 cycles after the slot edge.
//   Boundary conditions
//   - req_valid held high while req_ready=0 is ignored. The core must keep it high until it is accepted.
//   - Back-to-back requests: the next accept is possible on the edge after the DONE cycle.
//   - Reset asserted mid-operation aborts the request. mc_we drops immediately (asynchronously), and no
//     resp_valid pulse is issued for the aborted request.
//   - An address above the controller's region-offset threshold is passed through unmodified; the
//     controller applies its own remapping.
// TESTING  (SLOT_ID=1, NUM_SLOTS=8, memory model: combinational read)
//   1. Reset -> req_ready=1, resp_valid=0, mc_we=0, resp_rdata=0, slot_cnt=0.
//   2. Store addr 0x010 data 0xBEEF, accepted with slot_cnt=4 -> mc_we=1 until the edge with
//      slot_cnt=1, resp_valid in the next cycle, mem[0x010]=0xBEEF written exactly once.
//   3. Load 0x010 accepted with slot_cnt=6 -> the slot edge is the edge with slot_cnt=1; resp_valid is
//      high 10 cycles after it; resp_rdata=0xBEEF.
//   4. Request accepted exactly on the slot edge -> issued one full round later (8 cycles);
//      store written once.
//   5. rst_n low during WAIT_DATA -> mc_we=0 asynchronously; no resp_valid pulse; req_ready=1 after
//      rst_n returns high.
//   6. Eight instances (SLOT_ID 0..7) with simultaneous stores to distinct addresses -> all eight words
//      written, one per slot; each resp_valid pulse occurs in its own slot's following cycle.

Source files
------------

// File: rtl/mem_slot_requester.sv
// Single-entry request buffer for one core port of a time-division memory controller.
// Holds one load/store on the controller port until this port's slot, then pulses a response.
module mem_slot_requester #(
  parameter int SLOT_ID   = 0,
  parameter int NUM_SLOTS = 8,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16
) (
  input  logic              clk16,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_we,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic [DATA_W-1:0] mc_rdata
);
  localparam int CNT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] SLOT_VAL      = CNT_W'(SLOT_ID);
  localparam logic [CNT_W-1:0] DATA_SLOT_VAL = CNT_W'((SLOT_ID + 1) % NUM_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SLOT = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_slot_cnt;
  logic                r_armed;
  logic                w_armed_nxt;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [ADDR_W-1:0]   r_mc_addr;
  logic                r_mc_we;
  logic [DATA_W-1:0]   r_mc_wdata;
  logic                w_accept;
  logic                w_capture;
  logic                w_slot_edge;
  logic                w_data_edge;

  assign w_slot_edge = (r_slot_cnt == SLOT_VAL);
  assign w_data_edge = (r_slot_cnt == DATA_SLOT_VAL);

  // Next-state decode; r_armed distinguishes the data edge one full round after the slot edge.
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_armed_nxt = 1'b0;
          w_state_nxt = S_WAIT_SLOT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_SLOT: begin
        if (w_slot_edge) begin
          w_armed_nxt = 1'b0;
          w_state_nxt = r_mc_we ? S_DONE : S_WAIT_DATA;
        end else begin
          w_state_nxt = S_WAIT_SLOT;
        end
      end
      S_WAIT_DATA: begin
        if (w_slot_edge) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed && w_data_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT_DATA;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Free-running slot counter kept in phase with the controller's round-robin counter.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + CNT_W'(1);
    end
  end

  // State register plus handshake/response flags registered from the next state.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_armed      <= w_armed_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Controller-facing request; the write enable drops on the slot edge so a store lands once.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      r_mc_addr  <= '0;
      r_mc_we    <= 1'b0;
      r_mc_wdata <= '0;
    end else if (w_accept) begin
      r_mc_addr  <= req_addr;
      r_mc_we    <= req_we;
      r_mc_wdata <= req_wdata;
    end else if ((r_state == S_WAIT_SLOT) && w_slot_edge) begin
      r_mc_we    <= 1'b0;
    end
  end

  // Load data capture; holds until the next load completes.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_rdata <= '0;
    end else if (w_capture) begin
      r_resp_rdata <= mc_rdata;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mc_addr    = r_mc_addr;
  assign mc_we      = r_mc_we;
  assign mc_wdata   = r_mc_wdata;

endmodule

// File: tb/tb_mem_slot_requester.sv
// Eight requesters (SLOT_ID 0..7) sharing a modelled controller and memory,
// checked every cycle against a timeline model of request/slot/response timing.
module tb_mem_slot_requester;
  logic        clk;
  logic        rst_n;
  logic [7:0]  req_valid;
  logic [7:0]  req_we;
  logic [11:0] req_addr  [8];
  logic [15:0] req_wdata [8];
  logic [7:0]  req_ready;
  logic [7:0]  resp_valid;
  logic [15:0] resp_rdata [8];
  logic [11:0] mc_addr   [8];
  logic [7:0]  mc_we;
  logic [15:0] mc_wdata  [8];
  logic [15:0] rdata_q   [8];

  for (genvar g = 0; g < 8; g++) begin : g_inst
    mem_slot_requester #(.SLOT_ID(g), .NUM_SLOTS(8), .ADDR_W(12), .DATA_W(16)) u_dut (
      .clk16(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .req_ready(req_ready[g]), .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
      .mc_addr(mc_addr[g]), .mc_we(mc_we[g]), .mc_wdata(mc_wdata[g]),
      .mc_rdata(rdata_q[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller stand-in: round-robin slots, write on the slot edge, registered combinational read.
  logic [2:0] ctrl_cnt;
  bit [15:0]  mem     [4096];
  int         wcount  [4096];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_cnt <= 3'd0;
      for (int i = 0; i < 8; i++) rdata_q[i] <= 16'h0000;
    end else begin
      ctrl_cnt <= ctrl_cnt + 3'd1;
      if (mc_we[ctrl_cnt]) begin
        mem[mc_addr[ctrl_cnt]]    <= mc_wdata[ctrl_cnt];
        wcount[mc_addr[ctrl_cnt]] <= wcount[mc_addr[ctrl_cnt]] + 1;
      end
      rdata_q[ctrl_cnt] <= mem[mc_addr[ctrl_cnt]];
    end
  end

  // Timeline model: each accepted request gets its slot edge and response edge up front.
  int          total;
  int          bad;
  int          E;
  int          mode;
  bit [15:0]   ref_mem [4096];
  bit          m_act   [8];
  bit          m_we    [8];
  int          m_es    [8];
  int          m_resp  [8];
  logic [11:0] m_addr  [8];
  logic [15:0] m_wdata [8];
  logic [15:0] m_rd    [8];
  bit [7:0]    acc;
  bit [7:0]    x_ready, x_resp, x_we;
  logic [11:0] x_addr  [8];
  logic [15:0] x_wdata [8];
  logic [15:0] x_rdata [8];
  logic [11:0] pool    [8];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    E = 0;
    acc = 8'h00; x_ready = 8'hFF; x_resp = 8'h00; x_we = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 1'b0;
      x_addr[i] = 12'h000; x_wdata[i] = 16'h0000; x_rdata[i] = 16'h0000;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 8; i++) begin
      int d;
      acc[i] = 1'b0;
      if (m_act[i] && E >= m_resp[i] + 2) m_act[i] = 1'b0;
      if (!m_act[i] && req_valid[i]) begin
        d = (i - (E % 8) + 8) % 8;
        if (d == 0) d = 8;
        m_act[i] = 1'b1; m_we[i] = req_we[i];
        m_addr[i] = req_addr[i]; m_wdata[i] = req_wdata[i];
        m_es[i] = E + d;
        m_resp[i] = req_we[i] ? E + d : E + d + 9;
        x_addr[i] = req_addr[i]; x_wdata[i] = req_wdata[i];
        acc[i] = 1'b1;
      end
      if (m_act[i] && m_we[i] && E == m_es[i]) ref_mem[m_addr[i]] = m_wdata[i];
      if (m_act[i] && !m_we[i] && E == m_es[i] + 8) m_rd[i] = ref_mem[m_addr[i]];
      if (m_act[i] && !m_we[i] && E == m_resp[i]) x_rdata[i] = m_rd[i];
      x_ready[i] = !(m_act[i] && E <= m_resp[i]);
      x_resp[i]  = m_act[i] && (E == m_resp[i]);
      x_we[i]    = m_act[i] && m_we[i] && (E < m_es[i]);
    end
    E++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 8; i++) begin
      chk("req_ready",  i, 32'(req_ready[i]),  32'(x_ready[i]));
      chk("resp_valid", i, 32'(resp_valid[i]), 32'(x_resp[i]));
      chk("mc_we",      i, 32'(mc_we[i]),      32'(x_we[i]));
      chk("mc_addr",    i, 32'(mc_addr[i]),    32'(x_addr[i]));
      chk("mc_wdata",   i, 32'(mc_wdata[i]),   32'(x_wdata[i]));
      chk("resp_rdata", i, 32'(resp_rdata[i]), 32'(x_rdata[i]));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      if (req_valid[i] && acc[i]) begin
        req_valid[i] = 1'b0;
      end else if (!req_valid[i] && mode == 1 && $urandom_range(0, 2) != 0) begin
        req_valid[i] = 1'b1;
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = pool[$urandom_range(0, 7)];
        req_wdata[i] = 16'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    if (rst_n) compare_all();
    #1;
    drive();
  endtask

  task automatic directed(input string nm, input logic we, input logic [11:0] a, input logic [15:0] d,
                          input int c, input int lat_exp, input int wec_exp, input logic [15:0] rd_exp);
    int guard, lat, wec, wc0;
    guard = 0;
    while (!(x_ready[1] && (E % 8) == c) && guard < 64) begin step(); guard++; end
    chk({nm, "_start"}, 1, 32'(guard < 64), 32'd1);
    wc0 = wcount[a];
    req_valid[1] = 1'b1; req_we[1] = we; req_addr[1] = a; req_wdata[1] = d;
    step();
    lat = -1; wec = 0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (resp_valid[1]) lat = k;
      else begin
        if (mc_we[1]) wec++;
        step();
      end
    end
    chk({nm, "_latency"}, 1, 32'(lat), 32'(lat_exp));
    chk({nm, "_we_cycles"}, 1, 32'(wec), 32'(wec_exp));
    if (we) begin
      chk({nm, "_writes"}, 1, 32'(wcount[a] - wc0), 32'd1);
      chk({nm, "_mem"}, 1, 32'(mem[a]), 32'(d));
    end else begin
      chk({nm, "_rdata"}, 1, 32'(resp_rdata[1]), 32'(rd_exp));
    end
    step(); step();
  endtask

  task automatic check_mem();
    for (int i = 0; i < 8; i++) chk("mem_pool", i, 32'(mem[pool[i]]), 32'(ref_mem[pool[i]]));
  endtask

  initial begin
    int lat6 [8];
    int guard;
    bit found;
    total = 0; bad = 0; mode = 0;
    pool = '{12'h000, 12'h010, 12'h123, 12'h7FF, 12'h800, 12'hA5A, 12'hFFE, 12'hFFF};
    req_valid = 8'h00; req_we = 8'h00;
    for (int i = 0; i < 8; i++) begin req_addr[i] = 12'h000; req_wdata[i] = 16'h0000; end
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step();
    chk("rst_ready", 0, 32'(req_ready), 32'h0000_00FF);
    chk("rst_resp",  0, 32'(resp_valid), 32'd0);
    chk("rst_we",    0, 32'(mc_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rst_rdata", i, 32'(resp_rdata[i]), 32'd0);
      chk("rst_addr",  i, 32'(mc_addr[i]), 32'd0);
      chk("rst_wdata", i, 32'(mc_wdata[i]), 32'd0);
    end
    rst_n = 1'b1;

    directed("store_cnt4", 1'b1, 12'h010, 16'hBEEF, 4, 5, 5, 16'h0000);
    directed("load_cnt6",  1'b0, 12'h010, 16'h0000, 6, 12, 0, 16'hBEEF);
    directed("store_on_slot", 1'b1, 12'h020, 16'h1234, 1, 8, 8, 16'h0000);

    guard = 0;
    while (!(x_ready == 8'hFF && (E % 8) == 0) && guard < 64) begin step(); guard++; end
    chk("all8_start", 0, 32'(guard < 64), 32'd1);
    for (int i = 0; i < 8; i++) begin
      req_valid[i] = 1'b1; req_we[i] = 1'b1;
      req_addr[i] = 12'h100 + 12'(i); req_wdata[i] = 16'hC000 + 16'(i);
      lat6[i] = -1;
    end
    step();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 8; i++) if (resp_valid[i] && lat6[i] < 0) lat6[i] = k;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("all8_latency", i, 32'(lat6[i]), 32'((i == 0) ? 8 : i));
      chk("all8_mem", i, 32'(mem[12'h100 + 12'(i)]), 32'(16'hC000 + 16'(i)));
      chk("all8_writes", i, 32'(wcount[12'h100 + 12'(i)]), 32'd1);
    end

    mode = 1;
    for (int k = 0; k < 1500; k++) step();
    mode = 0;
    for (int k = 0; k < 40; k++) step();
    check_mem();

    mode = 1;
    guard = 0; found = 1'b0;
    while (!found && guard < 400) begin
      step(); guard++;
      for (int i = 0; i < 8; i++)
        if (m_act[i] && !m_we[i] && (E - 1) >= m_es[i] && (E - 1) < m_resp[i] && x_we != 8'h00) found = 1'b1;
    end
    chk("rst_precond", 0, 32'(found), 32'd1);
    mode = 0;
    #1;
    rst_n = 1'b0;
    req_valid = 8'h00;
    #1;
    chk("rst_async_we", 0, 32'(mc_we), 32'd0);
    chk("rst_async_resp", 0, 32'(resp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_resp", k, 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("rst_ready_after", 0, 32'(req_ready), 32'h0000_00FF);

    mode = 1;
    for (int k = 0; k < 800; k++) step();
    mode = 0;
    for (int k = 0; k < 40; k++) step();
    check_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
